// File: rtl/weave_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a
// single-entry valid/ready output register with sticky frame/overrun flags.
module weave_uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic [1:0]    sync_q, sync_d;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;

    logic rx_s;
    logic tick;
    logic complete;
    logic stop_bad;

    assign rx_s = sync_q[1];
    assign tick = (cnt_q == '0);

    always_comb begin
        sync_d = {sync_q[0], rx};
    end

    // Sampling FSM: counter reloads at every bit boundary so it never wraps.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        complete = 1'b0;
        stop_bad = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_s) begin
                    state_d = S_START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            S_START: begin
                if (tick) begin
                    if (rx_s) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DATA;
                        bit_d   = 3'd0;
                        cnt_d   = BIT_RELOAD;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift_q[7:1]};
                    cnt_d   = BIT_RELOAD;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (rx_s) begin
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end else begin
                        stop_bad = 1'b1;
                        state_d  = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            S_BREAK: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output register: a completing byte overrides consumption; set beats clear.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end
        if (err_clr) begin
            ferr_d = 1'b0;
            ovr_d  = 1'b0;
        end
        if (complete) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            if (valid_q && !rx_ready) begin
                ovr_d = 1'b1;
            end
        end
        if (stop_bad) begin
            ferr_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            data_q  <= 8'd0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: doc/weave_uart_rx.md
Name: weave_uart_rx

Overview:
- Serial receive front-end for the weaving tile. Deserialises 8N1 UART frames arriving on a dedicated input pin.
- Presents each received byte through a valid/ready handshake to downstream pattern/config logic, the consumer of received pattern bytes.
- Sits between ui_in (one bit used as the rx line) and the pattern register bank.
- Reports framing errors and overruns as sticky flags.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit period; legal range 4..255, even values only.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- rx  input  1  serial line, idle high, asynchronous to clk
- rx_data  output  8  last received byte, LSB = first data bit
- rx_valid  output  1  rx_data holds an unconsumed byte
- rx_ready  input  1  consumer accepts byte when rx_valid && rx_ready
- frame_err  output  1  sticky: stop bit sampled low
- overrun  output  1  sticky: byte completed while rx_valid still high
- err_clr  input  1  synchronous clear of frame_err and overrun
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset: one clock, clk; asynchronous, active-low reset rst_n. While rst_n low, all state is held at reset values:
  - rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
  - FSM = IDLE, bit counter = 0, sample counter = 0.
  - Both synchroniser flops = 1.
- Synchroniser: rx passes through 2 flops; rx_s is the output of the second flop. All FSM decisions use rx_s only.
- Let N = CLKS_PER_BIT and H = N/2.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - On the first cycle with rx_s==0, call it T0. Load sample counter, go to START.
- START:
  - At T0+H, sample rx_s.
  - If rx_s==1 (glitch): return to IDLE; no flags, no output.
  - Otherwise go to DATA with bit index 0.
- DATA:
  - Bit i (0..7) is sampled at T0+H+(i+1)*N and shifted into a shift register, LSB first.
  - After bit 7, go to STOP.
- STOP:
  - Sampled at T0+H+9N.
  - rx_s==1: the byte completes. At T0+H+9N+1, rx_data = shift register and rx_valid=1. Next state IDLE, so back-to-back frames are accepted with no gap.
  - rx_s==0: frame_err set at T0+H+9N+1. rx_data and rx_valid are unchanged. Go to BREAK.
- BREAK: wait until rx_s==1, then go to IDLE. A held-low line (break condition) therefore produces exactly one frame_err and no spurious bytes.
- Handshake:
  - rx_valid stays high until the cycle after a cycle with rx_valid && rx_ready.
  - rx_data is stable while rx_valid is high, except on overrun.
  - rx_ready while rx_valid==0 is ignored.
- Overrun:
  - A byte completes while rx_valid==1 and rx_ready==0 in that completion cycle: rx_data is overwritten with the new byte, rx_valid stays 1, overrun is set.
  - If rx_ready==1 in the same cycle as a completion: no overrun. The old byte is consumed and the new byte loaded, so rx_valid stays 1.
- Flag clear:
  - err_clr clears both flags on the next edge.
  - Set has priority over clear when both occur in the same cycle.
- Timing and counters:
  - busy is high in START, DATA, STOP and BREAK.
  - Latency from the rx pin falling edge to rx_valid is 2 + H + 9N + 1 cycles (±1 for the synchroniser phase).
  - Counters never wrap: the sample counter is reloaded to N-1 at each bit boundary. Counter width is $clog2(CLKS_PER_BIT).
- Reset mid-frame: the partial byte is discarded and the FSM returns to IDLE. After release, a line that is already low is treated as a new start (falls into START).

Test Plan:
- N=8, send 0xA5 with a correct stop bit, rx_ready held 0 -> rx_valid rises 2+4+72+1 cycles after the falling edge (±1), rx_data=0xA5, frame_err=0, overrun=0; assert rx_ready for 1 cycle -> rx_valid=0 the next cycle.
- Pulse rx low for 3 cycles (less than H+2) -> FSM returns to IDLE, busy drops, no rx_valid, no flags.
- Send 0x3C with the stop bit driven 0, then hold the line low for 40 cycles, then high -> frame_err=1 exactly once, rx_valid=0, busy stays 1 until the line goes high; err_clr -> frame_err=0.
- Send 0x11 then 0x22 back-to-back with rx_ready=0 -> after the second byte rx_data=0x22, rx_valid=1, overrun=1; repeat with rx_ready=1 held -> overrun stays 0 and both bytes are observed in order.
- Assert rst_n low during data bit 4 of a frame, release during a high line -> all outputs 0, next frame 0xFF received correctly.
- Randomised bytes at N=16 with ±2% baud skew on the stimulus -> every byte received correctly with no flags.
